// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - shares one line-granular memory port between icache and dcache
// Data cache has priority; a starvation counter bounds how long an icache read can wait.
module pmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic              owner_i;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic [CNT_W-1:0]  cnt;

  logic i_req;
  logic d_req;
  logic grant;
  logic grant_i;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_i   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant     = 1'b1;
          // icache only overtakes a pending dcache request once it has been starved long enough
          grant_i   = i_req && (!d_req || (cnt == CNT_MAX));
          state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (mem_resp) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_i   <= 1'b0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt       <= '0;
    end else begin
      if (grant) begin
        owner_i  <= grant_i;
        addr_q   <= grant_i ? i_pmem_address : d_pmem_address;
        // a simultaneous read+write from the dcache is treated as a write-back
        op_write <= !grant_i && d_pmem_write;
        if (!grant_i && d_pmem_write) begin
          wdata_q <= d_pmem_wdata;
        end
        if (grant_i || !i_req) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if ((state == SERVE) && mem_resp) begin
        if (owner_i) begin
          i_rdata_q <= mem_rdata;
        end else begin
          d_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_read     = (state == SERVE) && !op_write;
  assign mem_write    = (state == SERVE) && op_write;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_pmem_resp  = (state == RESP) && owner_i;
  assign d_pmem_resp  = (state == RESP) && !owner_i;
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_rdata = d_rdata_q;

endmodule
